// File: rtl/i2c_tx_engine.sv
// I2C transmit datapath: a small word FIFO feeding a bit shifter that moves on
// the falling edges of the synchronised SCL. It also samples the slave's ACK and flushes the FIFO on NACK.
module i2c_tx_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_WIDTH-1:0]             tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   input  logic                              tx_en,
   input  logic                              scl_in,
   input  logic                              sda_in,
   output logic                              sda_out,
   output logic                              busy,
   output logic                              byte_done,
   output logic                              nack,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int CW = $clog2(DATA_WIDTH+1);

   typedef enum logic [1:0] {IDLE, SHIFT, ACK_WAIT, ACK_END} state_t;

   logic scl_s1, scl_s, scl_d, sda_s1, sda_s;
   logic scl_fall, scl_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s1 <= 1'b1;
         scl_s  <= 1'b1;
         scl_d  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s  <= 1'b1;
      end else begin
         scl_s1 <= scl_in;
         scl_s  <= scl_s1;
         scl_d  <= scl_s;
         sda_s1 <= sda_in;
         sda_s  <= sda_s1;
      end
   end

   assign scl_fall = scl_d & ~scl_s;
   assign scl_rise = ~scl_d & scl_s;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wptr, rptr;
   logic [LW-1:0]         count;
   logic                  full, empty, push, pop;
   logic [DATA_WIDTH-1:0] head;

   assign full       = (count == LW'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign tx_ready   = ~full;
   assign fifo_level = count;
   assign head       = mem[rptr];
   // A NACK flushes the FIFO, so a write arriving in that same cycle is lost too.
   assign push       = tx_valid & tx_ready & ~nack;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (nack) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   state_t                state, state_nx;
   logic [CW-1:0]         bit_cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] shreg, sh_nx;
   logic                  sda_nx, acked, acked_nx, start;
   logic                  first_bit, next_bit;
   logic [DATA_WIDTH-1:0] head_sh, shreg_sh;

   assign first_bit = (MSB_FIRST != 0) ? head[DATA_WIDTH-1]  : head[0];
   assign next_bit  = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
   assign head_sh   = (MSB_FIRST != 0) ? {head[DATA_WIDTH-2:0], 1'b0}  : {1'b0, head[DATA_WIDTH-1:1]};
   assign shreg_sh  = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, shreg[DATA_WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         sda_out <= 1'b1;
         acked   <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= cnt_nx;
         shreg   <= sh_nx;
         sda_out <= sda_nx;
         acked   <= acked_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = bit_cnt;
      sh_nx     = shreg;
      sda_nx    = sda_out;
      acked_nx  = acked;
      pop       = 1'b0;
      start     = 1'b0;
      byte_done = 1'b0;
      nack      = 1'b0;
      if (!tx_en) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         sda_nx   = 1'b1;
      end else begin
         case (state)
            IDLE:
               start = scl_fall & ~empty;
            SHIFT:
               if (scl_fall) begin
                  if (bit_cnt < CW'(DATA_WIDTH)) begin
                     sda_nx = next_bit;
                     sh_nx  = shreg_sh;
                     cnt_nx = bit_cnt + CW'(1);
                  end else begin
                     sda_nx   = 1'b1;
                     cnt_nx   = '0;
                     state_nx = ACK_WAIT;
                  end
               end
            ACK_WAIT:
               if (scl_rise) begin
                  byte_done = ~sda_s;
                  nack      = sda_s;
                  acked_nx  = ~sda_s;
                  state_nx  = ACK_END;
               end
            ACK_END:
               if (scl_fall) begin
                  if (acked && !empty) begin
                     start = 1'b1;
                  end else begin
                     state_nx = IDLE;
                     sda_nx   = 1'b1;
                  end
               end
            default: begin
               state_nx = IDLE;
               sda_nx   = 1'b1;
            end
         endcase
         // Word load is shared by the idle start and the back-to-back path.
         if (start) begin
            pop      = 1'b1;
            sda_nx   = first_bit;
            sh_nx    = head_sh;
            cnt_nx   = CW'(1);
            state_nx = SHIFT;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Scoreboard bench for i2c_tx_engine: words accepted by a queue model are
// expected on the bus; a monitor rebuilds each word from SDA samples at SCL rise.
module tb_i2c_tx_engine;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int LW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          tx_en = 1'b0;
   logic          scl_in = 1'b1;
   logic          sda_in = 1'b0;
   logic          sda_out, busy, byte_done, nack;
   logic [LW-1:0] fifo_level;

   typedef struct packed {logic [W-1:0] word; logic exp_nack;} exp_t;

   exp_t sb[$];
   bit   hist[$];
   int   checks = 0, errors = 0;
   int   done_cnt = 0, nack_cnt = 0, model_level = 0;

   i2c_tx_engine #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .MSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_en(tx_en), .scl_in(scl_in), .sda_in(sda_in),
      .sda_out(sda_out), .busy(busy), .byte_done(byte_done), .nack(nack),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge scl_in) hist.push_back(sda_out);

   // Monitor: every ACK/NACK pulse retires the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && (byte_done || nack)) begin
         exp_t         e;
         logic [W-1:0] got, exp_seq;
         int           n;
         if (byte_done) done_cnt++;
         if (nack) nack_cnt++;
         check("pulse_exclusive", {31'd0, byte_done & nack}, 32'd0);
         n = hist.size();
         if (sb.size() == 0 || n <= W) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got pulse with %0d queued, %0d samples; required a queued word", sb.size(), n);
         end else begin
            e = sb.pop_front();
            got = '0;
            for (int i = 0; i < W; i++) got = {got[W-2:0], hist[n-1-W+i]};
            exp_seq = e.word;
            check("word_bits", {24'd0, got}, {24'd0, exp_seq});
            check("ack_slot_released", {31'd0, hist[n-1]}, 32'd1);
            check("ack_kind", {31'd0, nack}, {31'd0, e.exp_nack});
            if (nack) sb.delete();
         end
      end
   end

   task automatic push(input logic [W-1:0] w);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      if (model_level < D) begin
         model_level++;
         sb.push_back('{word: w, exp_nack: sda_in});
      end
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         logic s;
         scl_in = 1'b0;
         repeat (10) @(negedge clk);
         scl_in = 1'b1;
         @(negedge clk);
         s = sda_out;
         repeat (9) @(negedge clk);
         check("sda_stable_scl_high", {31'd0, sda_out}, {31'd0, s});
      end
   endtask

   initial begin
      int d0, n0, nw;
      bit saw;
      logic nk;

      repeat (3) @(negedge clk);
      check("rst_sda", {31'd0, sda_out}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, byte_done}, 32'd0);
      check("rst_nack", {31'd0, nack}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      rst_n = 1'b1;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);

      // Single word 0xA5, ACKed.
      sda_in = 1'b0;
      d0 = done_cnt;
      push(8'hA5);
      check("a5_level_pushed", {29'd0, fifo_level}, model_level);
      pulses(1);
      model_level--;
      check("a5_level_popped", {29'd0, fifo_level}, model_level);
      check("a5_busy", {31'd0, busy}, 32'd1);
      pulses(8);
      check("a5_done_count", done_cnt - d0, 32'd1);
      pulses(1);
      repeat (4) @(negedge clk);
      check("a5_idle_busy", {31'd0, busy}, 32'd0);
      check("a5_idle_sda", {31'd0, sda_out}, 32'd1);

      // Back-to-back 0x3C, 0xFF.
      d0 = done_cnt;
      push(8'h3C);
      push(8'hFF);
      check("b2b_level2", {29'd0, fifo_level}, model_level);
      pulses(1);
      model_level--;
      check("b2b_level1", {29'd0, fifo_level}, model_level);
      pulses(9);
      model_level--;
      check("b2b_level0", {29'd0, fifo_level}, model_level);
      check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
      pulses(8);
      check("b2b_done_count", done_cnt - d0, 32'd2);
      pulses(1);
      repeat (4) @(negedge clk);
      check("b2b_idle_busy", {31'd0, busy}, 32'd0);

      // NACK on the first of three words flushes the rest; a write in the flush cycle is lost.
      sda_in = 1'b1;
      d0 = done_cnt;
      n0 = nack_cnt;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      check("nack_level3", {29'd0, fifo_level}, model_level);
      saw = 1'b0;
      fork
         pulses(9);
         begin
            for (int k = 0; k < 400 && !saw; k++) begin
               @(negedge clk);
               if (nack) begin
                  saw      = 1'b1;
                  tx_data  = 8'h5A;
                  tx_valid = 1'b1;
                  @(negedge clk);
                  tx_valid = 1'b0;
               end
            end
         end
      join
      model_level = 0;
      check("nack_seen", {31'd0, saw}, 32'd1);
      check("nack_count", nack_cnt - n0, 32'd1);
      check("nack_no_done", done_cnt - d0, 32'd0);
      check("nack_flushed", {29'd0, fifo_level}, model_level);
      pulses(1);
      repeat (4) @(negedge clk);
      check("nack_idle_busy", {31'd0, busy}, 32'd0);
      check("nack_idle_sda", {31'd0, sda_out}, 32'd1);
      sda_in = 1'b0;

      // Full FIFO drops 0x77.
      d0 = done_cnt;
      for (int i = 0; i < D; i++) push(W'($urandom_range(0, 255)));
      check("full_level", {29'd0, fifo_level}, model_level);
      check("full_not_ready", {31'd0, tx_ready}, 32'd0);
      repeat (3) push(8'h77);
      check("full_level_after_drop", {29'd0, fifo_level}, model_level);
      pulses(9 * D + 1);
      model_level = 0;
      check("full_done_count", done_cnt - d0, D);
      check("full_drained", {29'd0, fifo_level}, model_level);
      check("full_sb_empty", sb.size(), 32'd0);

      // Abort mid-word 0x81 with tx_en=0.
      d0 = done_cnt;
      n0 = nack_cnt;
      push(8'h81);
      push(W'($urandom_range(0, 255)));
      push(W'($urandom_range(0, 255)));
      pulses(4);
      model_level--;
      tx_en = 1'b0;
      @(negedge clk);
      check("abort_sda", {31'd0, sda_out}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_level", {29'd0, fifo_level}, model_level);
      pulses(3);
      check("abort_no_pulses", (done_cnt - d0) + (nack_cnt - n0), 32'd0);
      check("abort_retained", {29'd0, fifo_level}, model_level);
      void'(sb.pop_front());
      tx_en = 1'b1;
      pulses(19);
      model_level = 0;
      check("abort_resume_done", done_cnt - d0, 32'd2);
      check("abort_resume_level", {29'd0, fifo_level}, model_level);

      // Random rounds, occasionally NACKed.
      for (int r = 0; r < 6; r++) begin
         nw = $urandom_range(1, D);
         nk = ($urandom_range(0, 3) == 0);
         sda_in = nk;
         d0 = done_cnt;
         n0 = nack_cnt;
         for (int i = 0; i < nw; i++) push(W'($urandom));
         if (nk) begin
            pulses(10);
            check("rnd_nack_count", nack_cnt - n0, 32'd1);
         end else begin
            pulses(9 * nw + 1);
            check("rnd_done_count", done_cnt - d0, nw);
         end
         model_level = 0;
         check("rnd_level", {29'd0, fifo_level}, model_level);
         check("rnd_sb_empty", sb.size(), 32'd0);
      end
      sda_in = 1'b0;

      // Reset mid-word.
      d0 = done_cnt;
      push(W'($urandom));
      push(W'($urandom));
      pulses(4);
      rst_n = 1'b0;
      #1;
      check("midrst_sda", {31'd0, sda_out}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, byte_done}, 32'd0);
      check("midrst_nack", {31'd0, nack}, 32'd0);
      check("midrst_level", {29'd0, fifo_level}, 32'd0);
      check("midrst_ready", {31'd0, tx_ready}, 32'd1);
      sb.delete();
      model_level = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pulses(12);
      check("postrst_sda", {31'd0, sda_out}, 32'd1);
      check("postrst_busy", {31'd0, busy}, 32'd0);
      check("postrst_no_done", done_cnt - d0, 32'd0);

      check("final_sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
